// File: rtl/mc_pkg.sv
// Shared constants for the mc_core multicycle CPU: opcode classes, opcodes,
// ALU operation and FSM state encodings, instruction field positions.
package mc_pkg;

  localparam int OP_LO  = 26;
  localparam int RS_LO  = 21;
  localparam int RT_LO  = 16;
  localparam int RD_LO  = 11;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = 16;

  localparam logic [1:0] CLS_R = 2'b00;
  localparam logic [1:0] CLS_I = 2'b01;

  localparam logic [5:0] OP_LW   = 6'b10_0000;
  localparam logic [5:0] OP_SW   = 6'b10_0001;
  localparam logic [5:0] OP_BEQ  = 6'b11_0000;
  localparam logic [5:0] OP_BNE  = 6'b11_0001;
  localparam logic [5:0] OP_J    = 6'b11_0010;
  localparam logic [5:0] OP_HALT = 6'b11_1111;

  // codes 8..15 are unnamed and behave as ADD
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for mc_core; all arithmetic wraps, zero flag drives branches.
module mc_alu
  import mc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result[0] = $signed(a) < $signed(b);
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mc_core.sv
// Multicycle CPU core: FSM, register file, datapath and req/ack memory ports.
// Optional performance counters are built when PERF_CNT_EN is defined.
module mc_core
  import mc_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 16,
  parameter int                NREG     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
);

  localparam int RW = $clog2(NREG);

  state_e            state, nxt;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, alu_out, mdr;
  logic [DATA_W-1:0] rf [NREG];

  logic [5:0]        op;
  logic              is_alu, is_r, is_lw, is_sw, is_beq, is_bne, is_j, is_halt, is_br;
  logic [RW-1:0]     rs, rt, dst;
  logic [DATA_W-1:0] sext, alu_b, alu_y;
  logic              alu_z, taken;
  alu_op_e           alu_op;

  assign op      = ir[OP_LO +: 6];
  assign is_r    = (op[5:4] == CLS_R);
  assign is_alu  = is_r || (op[5:4] == CLS_I);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_j    = (op == OP_J);
  assign is_halt = (op == OP_HALT);
  assign is_br   = is_beq || is_bne;
  assign rs      = ir[RS_LO +: RW];
  assign rt      = ir[RT_LO +: RW];
  assign dst     = is_r ? ir[RD_LO +: RW] : rt;
  assign sext    = DATA_W'($signed(ir[IMM_LO +: IMM_W]));

  // Branches compare through SUB; loads/stores force ADD for address generation.
  assign alu_op = is_alu ? alu_op_e'(op[3:0]) : (is_br ? ALU_SUB : ALU_ADD);
  assign alu_b  = (is_r || is_br) ? b : sext;
  assign taken  = (is_beq && alu_z) || (is_bne && !alu_z);

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .a(a), .b(alu_b), .op(alu_op), .result(alu_y), .zero(alu_z)
  );

  // run holds fetch requests off for one cycle so a stale ack after reset is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= nxt;
      run   <= 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  if (run && imem_ack) nxt = S_DECODE;
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        if (is_alu)              nxt = S_WB;
        else if (is_lw || is_sw) nxt = S_MEM;
        else if (is_halt)        nxt = S_HALT;
        else                     nxt = S_FETCH;
      end
      S_MEM:    if (dmem_ack) nxt = is_sw ? S_FETCH : S_WB;
      S_WB:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req   = (state == S_FETCH) && run;
    imem_addr  = pc;
    dmem_req   = (state == S_MEM);
    dmem_we    = is_sw;
    dmem_addr  = alu_out[ADDR_W-1:0];
    dmem_wdata = b;
    halted     = (state == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (run && imem_ack) begin
          ir <= imem_rdata;
          pc <= pc + ADDR_W'(1);
        end
        S_DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
        end
        S_EXEC: begin
          alu_out <= alu_y;
          if (taken)     pc <= pc + ADDR_W'($signed(ir[IMM_LO +: IMM_W]));
          else if (is_j) pc <= ADDR_W'(ir[IMM_LO +: IMM_W]);
        end
        S_MEM:   if (dmem_ack && !is_sw) mdr <= dmem_rdata;
        S_WB:    if (dst != '0) rf[dst] <= is_lw ? mdr : alu_out;
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] cyc_q, ins_q;
  logic        retire;

  assign retire = (nxt == S_FETCH && (state == S_EXEC || state == S_MEM || state == S_WB)) ||
                  (nxt == S_HALT && state != S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state != S_HALT) cyc_q <= cyc_q + 32'd1;
      if (retire)          ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_core.sv
// Scoreboard bench for mc_core: directed programs, wait-state memory models,
// fetch and data transactions checked against hand-computed expectations.
module tb_mc_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata = '0;
  logic        halted;
  logic [31:0] cycle_cnt, instr_cnt;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  mc_core #(.DATA_W(32), .ADDR_W(16), .NREG(32), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } dtx_t;

  logic [31:0] imem [0:63];
  int          iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  logic [31:0] drdata = '0;
  logic        ipend = 1'b0;
  logic [15:0] iaddr_prev = '0;
  int          n_chk = 0, n_fail = 0;
  dtx_t        dq[$];
  logic [15:0] fq[$];

  localparam logic [31:0] HALT = 32'hFC00_0000;
  localparam logic [31:0] NOP  = 32'hE000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int f, input int rd, input int rs, input int rt);
    return {2'b00, 4'(f), 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction
  function automatic logic [31:0] i_op(input int f, input int rt, input int rs, input int imm);
    return {2'b01, 4'(f), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] m_op(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic push_f(input int a);
    fq.push_back(16'(a));
  endtask
  task automatic push_d(input logic we, input int addr, input logic [31:0] data);
    dtx_t e;
    e.we = we; e.addr = 16'(addr); e.data = data;
    dq.push_back(e);
  endtask
  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = HALT;
  endtask

  // memory responders: ack after the configured number of wait cycles
  always @(negedge clk) begin
    if (imem_req) begin
      if (ipend) chk("imem_addr_stable", imem_addr, iaddr_prev);
      if (icnt >= iwait) begin
        imem_ack = 1'b1; imem_rdata = imem[imem_addr[5:0]]; icnt = 0; ipend = 1'b0;
      end else begin
        imem_ack = 1'b0; icnt++; ipend = 1'b1; iaddr_prev = imem_addr;
      end
    end else begin
      imem_ack = 1'b0; icnt = 0; ipend = 1'b0;
    end
    if (dmem_req) begin
      if (dcnt >= dwait) begin
        dmem_ack = 1'b1; dmem_rdata = drdata; dcnt = 0;
      end else begin
        dmem_ack = 1'b0; dcnt++;
      end
    end else begin
      dmem_ack = 1'b0; dcnt = 0;
    end
  end

  // monitor: pops expectations whenever a handshake completes
  always @(negedge clk) begin
    #1;
    if (rst_n && imem_req && imem_ack) begin
      if (fq.size() == 0) chk("fetch_extra", imem_addr, 64'hFFFF_FFFF);
      else chk("fetch_addr", imem_addr, fq.pop_front());
    end
    if (rst_n && dmem_req && dmem_ack) begin
      if (dq.size() == 0) chk("dmem_extra", dmem_addr, 64'hFFFF_FFFF);
      else begin
        dtx_t e;
        e = dq.pop_front();
        chk("dmem_we", dmem_we, e.we);
        chk("dmem_addr", dmem_addr, e.addr);
        if (e.we) chk("dmem_wdata", dmem_wdata, e.data);
      end
    end
  end

  task automatic assert_rst();
    rst_n = 1'b0;
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_instr_cnt", instr_cnt, 0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("req_low_after_release", imem_req, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    assert_rst();
    repeat (2) @(negedge clk);
    release_rst();
  endtask

  task automatic run_until_halt(input string name, input int exp_cyc, input int exp_instr);
    int n = 0;
    int w = 0;
    @(posedge clk); #1;
    while (!imem_req && w < 10) begin @(posedge clk); #1; w++; end
    chk({name, "_req_rise"}, imem_req, 1);
    while (!halted && n < 500) begin @(posedge clk); #1; n++; end
    chk({name, "_cycles"}, n, exp_cyc);
    chk({name, "_halted"}, halted, 1);
    chk({name, "_instr_cnt"}, instr_cnt, PERF ? exp_instr : 0);
    chk({name, "_cycle_cnt"}, cycle_cnt, PERF ? exp_cyc + 1 : 0);
    repeat (3) @(negedge clk);
    chk({name, "_fetch_q_empty"}, fq.size(), 0);
    chk({name, "_dmem_q_empty"}, dq.size(), 0);
  endtask

  task automatic load_prog_a();
    clear_imem();
    imem[0] = i_op(0, 1, 0, 5);
    imem[1] = r_op(0, 2, 1, 1);
    imem[2] = m_op(6'b100001, 0, 2, 3);
    imem[3] = HALT;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // A: zero-wait basic program
    load_prog_a();
    iwait = 0; dwait = 0;
    for (int i = 0; i < 4; i++) push_f(i);
    push_d(1'b1, 3, 32'd10);
    do_reset();
    run_until_halt("progA", 15, 4);

    // B: two fetch wait states
    iwait = 2;
    for (int i = 0; i < 4; i++) push_f(i);
    push_d(1'b1, 3, 32'd10);
    do_reset();
    run_until_halt("progB", 23, 4);
    iwait = 0;

    // C: load with a wait state, then store the loaded value
    clear_imem();
    imem[0] = m_op(6'b100000, 0, 3, 7);
    imem[1] = m_op(6'b100001, 0, 3, 8);
    imem[2] = HALT;
    dwait = 1; drdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) push_f(i);
    push_d(1'b0, 7, 32'h0);
    push_d(1'b1, 8, 32'hDEAD_BEEF);
    do_reset();
    run_until_halt("progC", 14, 3);
    dwait = 0;

    // D: BEQ taken, BNE not taken, J, BNE taken backwards
    clear_imem();
    for (int i = 0; i < 4; i++) imem[i] = NOP;
    imem[4]  = m_op(6'b110000, 0, 0, 2);
    imem[7]  = m_op(6'b110001, 0, 0, 2);
    imem[8]  = m_op(6'b110010, 0, 0, 16'h0010);
    imem[16] = i_op(0, 1, 0, 1);
    imem[17] = m_op(6'b110001, 1, 0, -3);
    imem[15] = HALT;
    for (int i = 0; i < 5; i++) push_f(i);
    push_f(7); push_f(8); push_f(16); push_f(17); push_f(15);
    do_reset();
    run_until_halt("progD", 31, 10);

    // E: wrap, signed compare, r0 write drop, shifts, XOR, ALU code 9
    clear_imem();
    imem[0]  = i_op(0, 1, 0, 1);
    imem[1]  = r_op(1, 1, 0, 1);
    imem[2]  = m_op(6'b100001, 0, 1, 0);
    imem[3]  = r_op(5, 4, 1, 0);
    imem[4]  = m_op(6'b100001, 0, 4, 1);
    imem[5]  = r_op(0, 0, 1, 1);
    imem[6]  = m_op(6'b100001, 0, 0, 2);
    imem[7]  = i_op(0, 6, 0, 28);
    imem[8]  = r_op(7, 5, 1, 6);
    imem[9]  = m_op(6'b100001, 0, 5, 3);
    imem[10] = i_op(9, 7, 5, 16'h0010);
    imem[11] = m_op(6'b100001, 0, 7, 4);
    imem[12] = r_op(6, 8, 5, 6);
    imem[13] = r_op(4, 9, 8, 1);
    imem[14] = m_op(6'b100001, 0, 9, 5);
    imem[15] = HALT;
    for (int i = 0; i < 16; i++) push_f(i);
    push_d(1'b1, 0, 32'hFFFF_FFFF);
    push_d(1'b1, 1, 32'h0000_0001);
    push_d(1'b1, 2, 32'h0000_0000);
    push_d(1'b1, 3, 32'h0000_000F);
    push_d(1'b1, 4, 32'h0000_001F);
    push_d(1'b1, 5, 32'h0FFF_FFFF);
    do_reset();
    run_until_halt("progE", 63, 16);

    // F: reset asserted mid-MEM while the store is stalled
    load_prog_a();
    dwait = 1000;
    for (int i = 0; i < 3; i++) push_f(i);
    do_reset();
    begin
      int w = 0;
      while (!dmem_req && w < 50) begin @(posedge clk); #1; w++; end
      chk("progF_dmem_req_seen", dmem_req, 1);
    end
    repeat (2) @(posedge clk);
    #2;
    assert_rst();
    chk("progF_fetch_q_empty", fq.size(), 0);
    dwait = 0;
    for (int i = 0; i < 4; i++) push_f(i);
    push_d(1'b1, 3, 32'd10);
    repeat (2) @(negedge clk);
    release_rst();
    run_until_halt("progF", 15, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_core.md
Name: mc_core

Overview:
- Parametrised multicycle CPU core; successor to the externally-controlled multicycle datapath.
- Integrates the control FSM, datapath, register file and ALU in one block.
- Has separate instruction and data memory ports with req/ack handshakes, so memories may insert wait states.
- Adds reset, BNE/JUMP/HALT handling and word-addressed PC; sits between IMem/DMem wrappers at the top level.

Parameters:
- DATA_W, 32: register/ALU/data width; instruction word is fixed at 32 bits; legal range 16..64.
- ADDR_W, 16: instruction and data address width; word addressed.
- NREG, 32: register count; rs/rt/rd use the low clog2(NREG) bits; r0 reads zero and ignores writes.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address (= PC)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  ADDR_W  data address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle on loads
- dmem_rdata  in  DATA_W  load data
- halted  out  1  core stopped by HALT
- cycle_cnt  out  32  performance counter (see Optional Feature)
- instr_cnt  out  32  retired instructions (see Optional Feature)

Behaviour:
- Instruction fields: op [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0]; sext = imm sign-extended to DATA_W.
- op[5:4] = 00, R-type: rd = rs OP rt, with OP = op[3:0].
- op[5:4] = 01, I-type: rt = rs OP sext.
- op = 10_0000, LW: rt = mem[rs + sext].
- op = 10_0001, SW: mem[rs + sext] = rt.
- op = 11_0000, BEQ; op = 11_0001, BNE. Target = PC+1+sext, where PC+1 is the incremented PC.
- op = 11_0010, J: PC = imm zero-extended, truncated to ADDR_W.
- op = 11_1111, HALT.
- Any other op executes as a NOP.
- ALU op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 6 SLL by B[4:0], 7 SRL by B[4:0], 8–15 ADD. All arithmetic wraps modulo 2^DATA_W; no overflow flag.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: imem_req = 1, imem_addr = PC. On the edge where imem_ack = 1: IR <= imem_rdata, PC <= PC+1, go to DECODE.
  - DECODE: A <= R[rs], B <= R[rt]. Go to EXEC.
  - EXEC: ALUOut <= result.
    - R/I type → WB.
    - LW/SW → MEM.
    - Branch: taken → PC <= target; either outcome → FETCH.
    - J → PC <= target → FETCH.
    - NOP → FETCH.
    - HALT → HALT.
  - MEM: dmem_req = 1, dmem_addr = ALUOut[ADDR_W-1:0], dmem_wdata = B, dmem_we = store. On ack: LW latches MDR and goes to WB; SW goes to FETCH.
  - WB: write the register file (rd for R-type, rt otherwise; source is MDR for LW, else ALUOut). Go to FETCH.
  - HALT: absorbing; halted = 1. Only reset leaves it.
- Handshake rules:
  - req and its address/data are held stable until ack is sampled high; req is deasserted the cycle after.
  - ack may be asserted in the same cycle req rises (zero-wait memory). ack while req = 0 is ignored.
- Latency with zero-wait memories:
  - ALU op: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch/J/NOP: 3 cycles.
  - Each memory wait cycle adds 1.
- Reset (asynchronous, any state, including mid-handshake):
  - State = FETCH, PC = RESET_PC; IR, A, B, ALUOut, MDR = 0; all registers = 0.
  - Outputs: req = 0, halted = 0, counters = 0.
  - An outstanding memory transaction is abandoned; an ack arriving in the first cycle after reset is ignored, because req is low.
- PC wraps modulo 2^ADDR_W.
- A write to r0 is dropped.
- An instruction reading a register written by the previous instruction sees the new value; there is no hazard, because execution is serial.

Optional Feature:
- Macro PERF_CNT_EN.
- When defined:
  - cycle_cnt increments every cycle while not halted.
  - instr_cnt increments on each instruction completion (the transition into FETCH from EXEC/MEM/WB, and the entry to HALT).
  - Both counters wrap at 2^32.
- When undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package mc_pkg holds:
  - op-class and opcode constants (OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT);
  - ALU op enum;
  - FSM state enum;
  - field bit-position constants.
- Sub-module mc_alu: combinational (a, b, op) → (result, zero), parametrised by DATA_W.
- The register file stays inline as an array.

Test Plan:
- Reset with the PC held in FETCH, zero-wait memories; program: I-type ADD r1,r0,5; ADD r2,r1,r1; SW r2,3(r0); HALT. Required: dmem write addr 3, data 10; halted = 1 after 4+4+4+3 = 15 cycles.
- Same program with imem_ack delayed 2 cycles on every fetch. Required: imem_addr stable while waiting; same final result; halted after 23 cycles; instr_cnt = 4 with PERF_CNT_EN.
- LW r3,7(r0) with dmem_rdata = 0xDEADBEEF after 1 wait; then SW r3,8(r0). Required: write data 0xDEADBEEF to addr 8.
- BEQ r0,r0,+2 at PC 4 → next fetch addr 7. BNE r0,r0,+2 → next fetch addr PC+1. J 0x0010 → fetch addr 0x10.
- SUB r1,r0,r1 with r1 = 1. Required: r1 = all-ones (wrap). SLT of 0xFFFFFFFF vs 0 → 1. ADD r0,r1,r1, then SW r0 → stores 0.
- Assert rst_n low mid-MEM with dmem_req high. Required: dmem_req drops immediately; first fetch after release is at RESET_PC; all counters are 0.
